// File: rtl/avalon_ram_slave.sv
// avalon_ram_slave: word-organised Avalon-MM RAM slave with programmable wait states and a sticky error flag.
module avalon_ram_slave #(
   parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 1,
   parameter string       INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic        waitrequest,
   output logic [31:0] readdata,
   output logic        error
);
   localparam int AW = $clog2(DEPTH_WORDS);
   typedef enum logic {S_IDLE, S_WAIT} state_t;
   state_t state, state_nx;
   logic [4:0] cnt, cnt_nx, wc;
   logic req, done, legal;
   logic [29:0] woff;
   logic [AW-1:0] index;
   logic [31:0] mem [DEPTH_WORDS];

   assign req   = read | write;
   assign woff  = address[31:2] - BASE_ADDR[31:2];
   assign index = woff[AW-1:0];
   assign legal = woff < 30'(DEPTH_WORDS) && address[1:0] == 2'b00 && !(read && write);

`ifdef AVALON_RAM_RANDOM_WAIT_EN
   logic [7:0] lfsr;
   always_ff @(posedge clk or negedge reset)
      if (!reset) lfsr <= 8'hA5;
      else if (state == S_IDLE && req) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   assign wc = 5'(WAIT_CYCLES) + {3'b000, lfsr[1:0]};
`else
   assign wc = 5'(WAIT_CYCLES);
`endif

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      waitrequest = 1'b0;
      done        = 1'b0;
      if (state == S_IDLE) begin
         if (req && wc == 5'd0) done = 1'b1;
         else if (req) begin
            waitrequest = 1'b1;
            cnt_nx      = wc - 5'd1;
            state_nx    = S_WAIT;
         end
      end else if (!req) state_nx = S_IDLE;
      else if (cnt != 5'd0) begin
         waitrequest = 1'b1;
         cnt_nx      = cnt - 5'd1;
      end else begin
         done     = 1'b1;
         state_nx = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state    <= S_IDLE;
         cnt      <= 5'd0;
         readdata <= 32'h0;
         error    <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (done && !legal) error <= 1'b1;
         if (done && read && !write) readdata <= legal ? mem[index] : 32'hDEAD_BEEF;
      end

   always_ff @(posedge clk)
      if (reset && done && write && legal)
         for (int i = 0; i < 4; i++)
            if (byteenable[i]) mem[index][8*i +: 8] <= writedata[8*i +: 8];
endmodule

// File: tb/tb_avalon_ram_slave.sv
// tb_avalon_ram_slave: directed plus randomized checks of avalon_ram_slave against a word-array reference model.
module tb_avalon_ram_slave;
   localparam logic [31:0] BASE  = 32'hBFC0_0000;
   localparam int          DEPTH = 1024;
   localparam int          WC    = 1;

   logic clk = 1'b0, reset = 1'b0;
   logic [31:0] address = '0, wdata = '0, rdata;
   logic        rd = 1'b0, wr = 1'b0, wreq, err;
   logic [3:0]  be = '0;
   logic [31:0] a0 = '0, wd0 = '0, rdata0;
   logic        rd0 = 1'b0, wr0 = 1'b0, wreq0, err0;
   logic [3:0]  be0 = '0;

   int checks = 0, failures = 0;
   logic [31:0] mm [DEPTH];
   logic [31:0] rd_m = '0;
   logic        err_m = 1'b0;
   logic [7:0]  lf = 8'hA5;

   always #5 clk = ~clk;

   avalon_ram_slave #(.WAIT_CYCLES(WC)) dut (
      .clk(clk), .reset(reset), .address(address), .read(rd), .write(wr), .writedata(wdata),
      .byteenable(be), .waitrequest(wreq), .readdata(rdata), .error(err));

   avalon_ram_slave #(.WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .address(a0), .read(rd0), .write(wr0), .writedata(wd0),
      .byteenable(be0), .waitrequest(wreq0), .readdata(rdata0), .error(err0));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected waitrequest-high cycles for the next request, advancing the reference LFSR
   function automatic int exp_wait();
      int w = WC;
`ifdef AVALON_RAM_RANDOM_WAIT_EN
      w += int'(lf % 8'd4);
`endif
      lf = {lf[6:0], ^(lf & 8'hB8)};
      return w;
   endfunction

   task automatic xfer(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      int n, ew;
      logic lg;
      logic [31:0] idx;
      ew = exp_wait();
      @(negedge clk);
      address = a; rd = r; wr = w; wdata = d; be = b;
      #1;
      n = 0;
      while (wreq && n < 40) begin
         n++;
         @(negedge clk);
      end
      @(negedge clk);
      rd = 1'b0; wr = 1'b0;
      chk("wait_cycles", n, ew);
      lg  = a >= BASE && a < BASE + 32'(4 * DEPTH) && a % 4 == 0 && !(r && w);
      idx = (a - BASE) / 4;
      if (!lg) begin
         err_m = 1'b1;
         if (r && !w) rd_m = 32'hDEAD_BEEF;
      end else if (r) rd_m = mm[idx];
      else if (w)
         for (int i = 0; i < 4; i++)
            if (b[i]) mm[idx][8*i +: 8] = d[8*i +: 8];
      chk("readdata", rdata, rd_m);
      chk("error", err, err_m);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_wreq", wreq, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_err", err, 0);
      reset = 1'b1;

`ifndef AVALON_RAM_RANDOM_WAIT_EN
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         a0 = BASE + 32'(4 * i); wr0 = 1'b1; wd0 = 32'hC0DE_0000 + 32'(i); be0 = 4'hF;
         #1 chk("zw_wr_wreq", wreq0, 0);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         a0 = BASE + 32'(4 * i); wr0 = 1'b0; rd0 = 1'b1;
         #1 chk("zw_rd_wreq", wreq0, 0);
         if (i > 0) chk("zw_rdata", rdata0, 32'hC0DE_0000 + 32'(i - 1));
      end
      @(negedge clk);
      rd0 = 1'b0;
      chk("zw_rdata_last", rdata0, 32'hC0DE_0003);
      chk("zw_err", err0, 0);
`endif

      xfer(0, 1, BASE, 32'h2402_0005, 4'hF);
      xfer(1, 0, BASE, 0, 4'h0);
      chk("fetch", rdata, 32'h2402_0005);
      repeat (3) begin
         @(negedge clk);
         chk("fetch_hold", rdata, 32'h2402_0005);
      end

      xfer(0, 1, BASE + 32'h10, 32'h1122_3344, 4'b1111);
      xfer(0, 1, BASE + 32'h10, 32'hAABB_CCDD, 4'b0101);
      xfer(0, 1, BASE + 32'h10, 32'hFFFF_FFFF, 4'b0000);
      xfer(1, 0, BASE + 32'h10, 0, 4'h0);
      chk("partial", rdata, 32'h11BB_33DD);

      xfer(0, 1, BASE + 32'hFFC, 32'h7777_1234, 4'hF);
      xfer(1, 0, BASE + 32'hFFC, 0, 4'h0);
      chk("last_word", rdata, 32'h7777_1234);

      xfer(1, 0, 32'h0000_0004, 0, 4'h0);
      chk("illegal_low", rdata, 32'hDEAD_BEEF);
      chk("illegal_err", err, 1);
      xfer(1, 0, BASE + 32'h10, 0, 4'h0);
      xfer(1, 0, BASE + 32'h2, 0, 4'h0);
      chk("misaligned", rdata, 32'hDEAD_BEEF);
      xfer(1, 0, BASE + 32'h10, 0, 4'h0);
      xfer(1, 1, BASE + 32'h10, 32'h0, 4'hF);
      chk("rw_both_hold", rdata, 32'h11BB_33DD);
      xfer(0, 1, BASE + 32'h1000, 32'h0, 4'hF);
      xfer(0, 1, BASE - 32'h4, 32'h0, 4'hF);
      xfer(1, 0, BASE + 32'h10, 0, 4'h0);
      chk("ram_intact", rdata, 32'h11BB_33DD);
      xfer(1, 0, BASE, 0, 4'h0);
      chk("word0_intact", rdata, 32'h2402_0005);
      chk("err_sticky", err, 1);

      for (int i = 0; i < 16; i++) xfer(0, 1, BASE + 32'(4 * i), $urandom, 4'hF);
      for (int k = 0; k < 48; k++) begin
         logic [31:0] a;
         int sel, op;
         sel = int'($urandom_range(0, 9));
         op  = int'($urandom_range(0, 9));
         a = sel == 0 ? {2'b00, 30'($urandom)} :
             sel == 1 ? BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3)) :
                        BASE + 32'(4 * $urandom_range(0, 15));
         xfer(op < 5 || op == 9, op >= 5, a, $urandom, 4'($urandom));
      end

      void'(exp_wait());
      @(negedge clk);
      address = BASE + 32'h24; wr = 1'b1; wdata = 32'h0BAD_F00D; be = 4'hF;
      #1 chk("pv_wreq_hi", wreq, 1);
      @(negedge clk);
      wr = 1'b0;
      #1 chk("pv_wreq_lo", wreq, 0);
      @(negedge clk);
      chk("pv_idle", wreq, 0);
      chk("pv_rdata", rdata, rd_m);
      chk("pv_err", err, err_m);
      xfer(1, 0, BASE + 32'h24, 0, 4'h0);

      xfer(1, 0, BASE + 32'h20, 0, 4'h0);
      void'(exp_wait());
      @(negedge clk);
      address = BASE + 32'h20; wr = 1'b1; wdata = ~mm[8]; be = 4'hF;
      @(posedge clk);
      #2;
      reset = 1'b0; wr = 1'b0;
      #1;
      chk("mid_rst_wreq", wreq, 0);
      chk("mid_rst_rdata", rdata, 0);
      chk("mid_rst_err", err, 0);
      @(negedge clk);
      reset = 1'b1;
      lf = 8'hA5; rd_m = '0; err_m = 1'b0;
      xfer(1, 0, BASE + 32'h20, 0, 4'h0);
      for (int i = 0; i < 16; i++) xfer(1, 0, BASE + 32'(4 * $urandom_range(0, 15)), 0, 4'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
